// File: rtl/pixel_feeder.sv
// pixel_feeder: walks a DDR2 frame buffer in bursts and streams 24-bit pixels to the DVI block.
// Define PIXEL_FEEDER_UNDERRUN_CNT_EN to add the underrun_count output.
module pixel_feeder #(
   parameter int WIDTH      = 800,
   parameter int HEIGHT     = 600,
   parameter int BURST      = 8,
   parameter int FIFO_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [31:0] frame_base,
   output logic        rd_req_valid,
   input  logic        rd_req_ready,
   output logic [31:0] rd_req_addr,
   input  logic        rd_data_valid,
   input  logic [31:0] rd_data,
   output logic [23:0] video,
   output logic        video_valid,
   input  logic        video_ready,
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
   output logic [15:0] underrun_count,
`endif
   output logic        frame_interrupt
);
   localparam int NPIX = WIDTH * HEIGHT;
   localparam int NREQ = NPIX / BURST;
   localparam int IW   = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int PW   = NPIX > 1 ? $clog2(NPIX) : 1;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 2;
   localparam int SH   = $clog2(BURST * 4);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t        r_state, w_next;
   logic [31:0]   r_base;
   logic [IW-1:0] r_req_idx;
   logic [CW-1:0] r_outstanding, r_count;
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [23:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_pix_idx;
   logic          r_irq;
   logic          w_room, w_req_hs, w_last_req, w_last_pix, w_frame_start, w_wr, w_rd;
   logic          w_unused;

   // Words already requested count against FIFO space, so the FIFO can never overflow.
   assign w_room        = 32'(r_count) + 32'(r_outstanding) + 32'(BURST) <= 32'(FIFO_DEPTH);
   assign w_req_hs      = r_state == REQ && rd_req_ready;
   assign w_last_req    = r_req_idx == IW'(NREQ - 1);
   assign w_last_pix    = r_pix_idx == PW'(NPIX - 1);
   assign w_frame_start = (r_state == IDLE && enable) || (w_req_hs && w_last_req);
   assign w_wr          = rd_data_valid;
   assign w_rd          = video_valid && video_ready;
   assign w_unused      = &{1'b0, rd_data[31:24]};

   always_comb begin
      w_next = r_state;
      if (r_state == IDLE)
         w_next = enable ? (w_room ? REQ : WAIT) : IDLE;
      else if (r_state == REQ)
         w_next = rd_req_ready ? WAIT : REQ;
      else
         w_next = w_room ? REQ : WAIT;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_base        <= '0;
         r_req_idx     <= '0;
         r_outstanding <= '0;
         r_count       <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_pix_idx     <= '0;
         r_irq         <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_base        <= w_frame_start ? frame_base : r_base;
         r_req_idx     <= (r_state == IDLE || (w_req_hs && w_last_req)) ? '0 : r_req_idx + IW'(w_req_hs);
         r_outstanding <= r_outstanding + (w_req_hs ? CW'(BURST) : '0) - CW'(rd_data_valid);
         r_count       <= r_count + CW'(w_wr) - CW'(w_rd);
         r_wr_ptr      <= r_wr_ptr + AW'(w_wr);
         r_rd_ptr      <= r_rd_ptr + AW'(w_rd);
         r_pix_idx     <= (w_rd && w_last_pix) ? '0 : r_pix_idx + PW'(w_rd);
         r_irq         <= w_rd && w_last_pix;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= rd_data[23:0];
   end

   assign rd_req_valid    = r_state == REQ;
   assign rd_req_addr     = r_base + (32'(r_req_idx) << SH);
   assign video_valid     = r_count != '0;
   assign video           = video_valid ? r_mem[r_rd_ptr] : '0;
   assign frame_interrupt = r_irq;

`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
   logic [15:0] r_underrun;
   always_ff @(posedge clk) begin
      if (!rst_n || w_frame_start)
         r_underrun <= '0;
      else if (video_ready && !video_valid && r_state != IDLE && !(&r_underrun))
         r_underrun <= r_underrun + 16'd1;
   end
   assign underrun_count = r_underrun;
`endif

   assert property (@(posedge clk) disable iff (!rst_n) !(w_wr && !w_rd && r_count == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_pixel_feeder.sv
// tb_pixel_feeder: directed checks of pixel_feeder with a word=address memory model.
// Covers the PIXEL_FEEDER_UNDERRUN_CNT_EN port when that macro is defined.
module tb_pixel_feeder;
   logic        clk = 1'b0;
   logic        rst_n, enable, rd_req_ready, rd_data_valid, video_ready;
   logic        rd_req_valid, video_valid, frame_interrupt;
   logic [31:0] frame_base, rd_req_addr, rd_data;
   logic [23:0] video;
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
   logic [15:0] underrun_count;
   int          ur_max, ur_drop;
   logic [15:0] ur_last;
`endif

   typedef struct {logic [31:0] addr; int due;} mw_t;
   mw_t         mem_q[$];
   logic [31:0] req_q[$];
   logic [23:0] pix_q[$];
   int          irq_at[$];
   int          n_chk, n_pass, cyc, lat, limit, irq_cnt, ur_cycles;
   int          lat_bad, hold_bad, max_inflight;
   bit          vr_rand, stall_prev, dv_prev;
   logic [23:0] held;

   always #5 clk = ~clk;

   pixel_feeder #(.WIDTH(8), .HEIGHT(2), .BURST(4), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_base(frame_base),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .video(video), .video_valid(video_valid), .video_ready(video_ready),
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
      .underrun_count(underrun_count),
`endif
      .frame_interrupt(frame_interrupt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_for(input string tag, input int np, input int ni, input int nr);
      int t = 0;
      while ((pix_q.size() < np || irq_cnt < ni || req_q.size() < nr) && t < 2000) begin
         step(1);
         t++;
      end
      chk(tag, 32'(t < 2000), 32'd1);
   endtask

   // Memory model and stream monitor: drives inputs on the falling edge, so handshakes
   // computed here are exactly those the DUT sees on the following rising edge.
   initial begin
      rd_req_ready  = 1'b1;
      rd_data_valid = 1'b0;
      rd_data       = '0;
      video_ready   = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            mem_q.delete();
            rd_data_valid = 1'b0;
            video_ready   = 1'b0;
            stall_prev    = 1'b0;
            dv_prev       = 1'b0;
         end else begin
            if (frame_interrupt) begin
               irq_cnt++;
               irq_at.push_back(pix_q.size());
            end
            if (dv_prev && !video_valid) lat_bad++;
            if (stall_prev && (!video_valid || video !== held)) hold_bad++;
            rd_data_valid = mem_q.size() > 0 && mem_q[0].due <= cyc;
            if (rd_data_valid) rd_data = mem_q.pop_front().addr;
            video_ready = (vr_rand ? 1'($urandom_range(0, 1)) : 1'b1) && pix_q.size() < limit;
            if (rd_req_valid && rd_req_ready) begin
               req_q.push_back(rd_req_addr);
               for (int k = 0; k < 4; k++) mem_q.push_back('{rd_req_addr + 32'(4 * k), cyc + lat + k});
            end
            if (video_valid && video_ready) pix_q.push_back(video);
            if (video_ready && !video_valid) ur_cycles++;
            if (4 * req_q.size() - pix_q.size() > max_inflight) max_inflight = 4 * req_q.size() - pix_q.size();
            stall_prev = video_valid && !video_ready;
            held       = video;
            dv_prev    = rd_data_valid;
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
            if (int'(underrun_count) > ur_max) ur_max = int'(underrun_count);
            if (ur_last != 0 && underrun_count == 0) ur_drop++;
            ur_last = underrun_count;
`endif
         end
      end
   end

   initial begin
      rst_n = 1'b0; enable = 1'b1; frame_base = 32'h1000;
      lat = 3; limit = 16; vr_rand = 1'b0;
      step(3);
      chk("rst_req_valid", 32'(rd_req_valid), 0);
      chk("rst_req_addr", rd_req_addr, 0);
      chk("rst_video_valid", 32'(video_valid), 0);
      chk("rst_video", 32'(video), 0);
      chk("rst_irq", 32'(frame_interrupt), 0);
      rst_n = 1'b1;
      chk("t1_idle_req_valid", 32'(rd_req_valid), 0);
      step(1);
      chk("t1_first_req_valid", 32'(rd_req_valid), 1);
      chk("t1_first_req_addr", rd_req_addr, 32'h1000);

      // 1: first frame, reader never stalls (until 16 pixels are taken)
      wait_for("t1_done", 16, 1, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t1_req%0d", i), req_q[i], 32'h1000 + 32'(16 * i));
      for (int i = 0; i < 16; i++) chk($sformatf("t1_pix%0d", i), 32'(pix_q[i]), 32'h1000 + 32'(4 * i));
      chk("t1_irq_at", 32'(irq_at[0]), 16);

      // 2: reader stalled for 40 cycles at the start of frame 2
      step(40);
      chk("t2_video_valid", 32'(video_valid), 1);
      chk("t2_video_held", 32'(video), 32'h1000);
      chk("t2_req_count", 32'(req_q.size()), 6);
      chk("t2_req4", req_q[4], 32'h1000);
      chk("t2_req5", req_q[5], 32'h1010);
      chk("t2_hold", 32'(hold_bad), 0);
      chk("t2_pix_count", 32'(pix_q.size()), 16);

      // 3: new base mid-frame applies from the next frame
      frame_base = 32'h2000;
      limit = 32;
      wait_for("t3_done", 32, 2, 9);
      for (int i = 0; i < 4; i++) chk($sformatf("t3_req%0d", 4 + i), req_q[4 + i], 32'h1000 + 32'(16 * i));
      chk("t3_next_frame_req", req_q[8], 32'h2000);
      for (int i = 0; i < 16; i++) chk($sformatf("t3_pix%0d", i), 32'(pix_q[16 + i]), 32'h1000 + 32'(4 * i));
      chk("t3_irq_at", 32'(irq_at[1]), 32);

      // 4: slow memory causes underruns but no lost or repeated pixels
      lat = 20; ur_cycles = 0; limit = 48;
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
      ur_max = 0; ur_drop = 0;
`endif
      wait_for("t4_done", 48, 3, 12);
      for (int i = 0; i < 16; i++) chk($sformatf("t4_pix%0d", i), 32'(pix_q[32 + i]), 32'h2000 + 32'(4 * i));
      chk("t4_underruns_seen", 32'(ur_cycles > 0), 1);
      chk("t4_irq_at", 32'(irq_at[2]), 48);
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
      chk("t4_ur_count_nonzero", 32'(ur_max > 0), 1);
      chk("t4_ur_count_cleared", 32'(ur_drop > 0), 1);
`endif

      // 5: one-cycle reset after pixel 5 of frame 4, restart from the new base
      lat = 3; frame_base = 32'h3000; limit = 53;
      wait_for("t5_pix5", 53, 3, 0);
      step(3);
      rst_n = 1'b0;
      step(1);
      chk("t5_rst_req_valid", 32'(rd_req_valid), 0);
      chk("t5_rst_req_addr", rd_req_addr, 0);
      chk("t5_rst_video_valid", 32'(video_valid), 0);
      chk("t5_rst_video", 32'(video), 0);
      chk("t5_rst_irq", 32'(frame_interrupt), 0);
      pix_q.delete(); req_q.delete(); irq_at.delete();
      irq_cnt = 0; limit = 48; vr_rand = 1'b1;
      rst_n = 1'b1;
      step(1);
      chk("t5_restart_req_valid", 32'(rd_req_valid), 1);
      chk("t5_restart_req_addr", rd_req_addr, 32'h3000);

      // 6: random reader over three frames
      wait_for("t6_done", 48, 3, 12);
      step(20);
      chk("t6_handshakes", 32'(pix_q.size()), 48);
      chk("t6_irqs", 32'(irq_cnt), 3);
      for (int k = 0; k < 3; k++) chk($sformatf("t6_irq_at%0d", k), 32'(irq_at[k]), 32'(16 * (k + 1)));
      for (int i = 0; i < 48; i++) chk($sformatf("t6_pix%0d", i), 32'(pix_q[i]), 32'h3000 + 32'(4 * (i % 16)));
      for (int i = 0; i < 12; i++) chk($sformatf("t6_req%0d", i), req_q[i], 32'h3000 + 32'(16 * (i % 4)));

      chk("data_to_valid_latency", 32'(lat_bad), 0);
      chk("video_hold", 32'(hold_bad), 0);
      chk("inflight_le_fifo", 32'(max_inflight <= 8), 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
